// File: rtl/cla_seq_pkg.sv
// Shared definitions for the CLA add sequencer: state encoding,
// default slice geometry and requester id width.
package cla_seq_pkg;

   localparam int DEF_NBIT   = 4;
   localparam int DEF_NSLICE = 4;
   localparam int ID_W       = 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cla_add_sequencer_if.sv
// Two-requester add bus plus result port for cla_add_sequencer.
// slave: sequencer side (takes requests, drives results, busy).
// master: client side (drives requests and rsp_ready).
interface cla_add_sequencer_if
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = DEF_NBIT * DEF_NSLICE
) ();

   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_cin;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_cin;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_cout;
   logic [ID_W-1:0]  rsp_id;

   logic             busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin,
      input  req1_valid, req1_a, req1_b, req1_cin,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_sum, rsp_cout, rsp_id,
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_cin,
      output req1_valid, req1_a, req1_b, req1_cin,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_sum, rsp_cout, rsp_id,
      input  busy
   );

endinterface

// File: rtl/cla_nibble_slice.sv
// Combinational NBIT-bit carry-lookahead adder slice.
// Ports: a, b, cin in; sum, cout out.
module cla_nibble_slice #(
   parameter int NBIT = 4
) (
   input  logic [NBIT-1:0] a,
   input  logic [NBIT-1:0] b,
   input  logic            cin,
   output logic [NBIT-1:0] sum,
   output logic            cout
);

   logic [NBIT-1:0] g;
   logic [NBIT-1:0] p;
   logic [NBIT:0]   c;
   logic            pp;
   logic            cc;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is the full sum-of-products expansion
   // g[i] | p[i]g[i-1] | ... | p[i..0]cin, not a ripple chain.
   always_comb begin
      c    = '0;
      pp   = 1'b0;
      cc   = 1'b0;
      c[0] = cin;
      for (int i = 0; i < NBIT; i++) begin
         pp = p[i];
         cc = g[i];
         for (int j = i - 1; j >= 0; j--) begin
            cc = cc | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = cc | (pp & cin);
      end
   end

   assign sum  = p ^ c[NBIT-1:0];
   assign cout = c[NBIT];

endmodule

// File: rtl/cla_add_sequencer.sv
// Shares one CLA slice between two requesters, adding WIDTH-bit
// operands a slice per cycle. Ports: clk, rst_n, bus (slave).
module cla_add_sequencer
   import cla_seq_pkg::*;
#(
   parameter int NBIT   = DEF_NBIT,
   parameter int NSLICE = DEF_NSLICE
) (
   input logic                 clk,
   input logic                 rst_n,
   cla_add_sequencer_if.slave  bus
);

   localparam int WIDTH = NBIT * NSLICE;
   localparam int IDXW  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

   logic [1:0]       state;
   logic             ptr;
   logic [IDXW-1:0]  idx;
   logic             carry_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;
   logic [ID_W-1:0]  id_reg;

   logic             idle;
   logic             grant0;
   logic             grant1;
   logic             ready0;
   logic             ready1;
   logic             accept;
   logic [NBIT-1:0]  s_sum;
   logic             s_cout;

   assign idle = (state == ST_IDLE);

   // ptr==0 favours req0; the loser only wins when the
   // favoured port is idle, so both grants are never high.
   always_comb begin
      grant0 = bus.req0_valid && (!ptr || !bus.req1_valid);
      grant1 = bus.req1_valid && (ptr || !bus.req0_valid);
   end

   assign ready0 = idle && grant0;
   assign ready1 = idle && grant1;
   assign accept = ready0 || ready1;

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;

   cla_nibble_slice #(
      .NBIT (NBIT)
   ) u_slice (
      .a    (a_reg[idx*NBIT +: NBIT]),
      .b    (b_reg[idx*NBIT +: NBIT]),
      .cin  (carry_reg),
      .sum  (s_sum),
      .cout (s_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= 1'b0;
         idx       <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         id_reg    <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_reg     <= ready1 ? bus.req1_a : bus.req0_a;
                  b_reg     <= ready1 ? bus.req1_b : bus.req0_b;
                  carry_reg <= ready1 ? bus.req1_cin : bus.req0_cin;
                  id_reg    <= ID_W'(ready1);
                  ptr       <= ~ready1;
                  idx       <= '0;
                  state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum_reg[idx*NBIT +: NBIT] <= s_sum;
               carry_reg                 <= s_cout;
               if (idx == IDX_LAST) begin
                  cout_reg <= s_cout;
                  state    <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.rsp_valid = (state == ST_DONE);
   assign bus.rsp_sum   = sum_reg;
   assign bus.rsp_cout  = cout_reg;
   assign bus.rsp_id    = id_reg;
   assign bus.busy      = !idle;

endmodule

// File: doc/cla_add_sequencer.md
# cla_add_sequencer

Multi-cycle adder controller that shares one NBIT-wide carry-lookahead slice between two requesters. It performs WIDTH = NBIT*NSLICE bit additions by stepping the slice through operand nibbles, least-significant first, and chaining the carry through a register. It sits between the CLA slice datapath and two client ports. It provides round-robin arbitration, operand capture, slice sequencing and a valid/ready result port.

## Interface
- NBIT, 4, width of the CLA slice in bits
- NSLICE, 4, number of slices per operand; WIDTH = NBIT*NSLICE is a derived localparam (16 at defaults)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted when valid && ready at a rising edge
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_cin / req1_cin  in  1  carry-in
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed when valid && ready at a rising edge
- rsp_sum  out  WIDTH  (a + b + cin) mod 2^WIDTH
- rsp_cout  out  1  bit WIDTH of a + b + cin
- rsp_id  out  1  index of the requester that issued the result
- busy  out  1  high in RUN and DONE

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - RUN: slice being stepped.
  - DONE: result held for the consumer.
- IDLE arbitration:
  - grant = requester favoured by the round-robin pointer if it is valid, else the other one if it is valid.
  - reqN_ready = (state==IDLE) && grant==N. Ready is combinational from state and the valids; it is never high for both ports.
- Accept, on the edge where the granted port has valid && ready:
  - latch a, b, cin and id
  - carry_reg <= cin, idx <= 0, state <= RUN
  - pointer <= other requester
- RUN, each edge:
  - slice computes on a[idx*NBIT +: NBIT], b[idx*NBIT +: NBIT] and carry_reg
  - sum_reg[idx*NBIT +: NBIT] <= slice sum; carry_reg <= slice cout
  - if idx==NSLICE-1: state <= DONE, rsp_cout <= slice cout; else idx <= idx+1
- DONE:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id are stable.
  - On rsp_ready the state returns to IDLE. No new acceptance happens in the same edge.
- Captured operands are independent of later changes on the request ports.
- Reset values: state IDLE, pointer favours req0, idx 0, carry_reg 0, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, busy 0. req_ready follows the IDLE rule while in reset.
- Reset asserted mid-RUN or in DONE aborts the transaction. The result is lost, rsp_valid drops immediately (asynchronously), and no partial sum or carry survives.

## Timing
- Acceptance edge E0; slices are processed on edges E1..E_NSLICE; rsp_valid is high after edge E_NSLICE.
- Latency: NSLICE edges from acceptance to rsp_valid (4 at defaults).
- Minimum issue interval with rsp_ready held high is NSLICE+2 cycles: RUN×NSLICE, DONE×1, IDLE×1.
- With rsp_ready low, the block stalls in DONE indefinitely and both req_ready outputs stay 0.
- Both requesters held valid are served strictly alternately: 0,1,0,1…
- A single valid requester is served back-to-back regardless of the pointer.

## Structure
- Shared package cla_seq_pkg holds:
  - state encoding (IDLE, RUN, DONE)
  - default NBIT/NSLICE
  - requester id width
- One sub-module, cla_nibble_slice: combinational NBIT-bit carry-lookahead sum/cout from (a, b, cin). It is instantiated once.
- The FSM, arbiter, idx counter and sum/carry registers live in cla_add_sequencer.

## Test plan
- req0 a=0x1234 b=0x4321 cin=0 -> rsp_sum=0x5555, rsp_cout=0, rsp_id=0; rsp_valid rises exactly 4 edges after acceptance.
- req1 a=0xFFFF b=0x0000 cin=1 -> rsp_sum=0x0000, rsp_cout=1, rsp_id=1. Carry ripples through all four slices.
- Both valid from reset and held -> accepts req0, req1, req0 in order. Each result carries its correct id and sum; req0_ready and req1_ready are never high together.
- rsp_ready held low for 10 cycles in DONE -> rsp_sum/rsp_cout/rsp_id stable, busy=1, no acceptance. Release -> IDLE one edge later.
- rst_n pulsed low with idx==2 in RUN -> rsp_valid=0, busy=0 immediately. The next request a=0x000F b=0x0001 cin=0 -> 0x0010, cout 0, proving no stale carry.
- 0x8000+0x8000 cin=0 -> sum 0x0000, cout 1. Then 1000 random requests on both ports are checked against a+b+cin.
